// File: rtl/cga_video_pkg.sv
// Shared encodings for the CGA line doubler: scanline modes and output FSM states.
package cga_video_pkg;

    typedef enum logic [1:0] {
        SCAN_OFF   = 2'd0,
        SCAN_BLACK = 2'd1,
        SCAN_HALF  = 2'd2,
        SCAN_RSVD  = 2'd3
    } scan_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC0 = 3'd1,
        ST_LINE0 = 3'd2,
        ST_SYNC1 = 3'd3,
        ST_LINE1 = 3'd4
    } out_state_e;

endpackage

// File: rtl/cga_linedoubler_if.sv
// Pixel-in / doubled-video-out bundle between the pixel pusher, line doubler and output mux.
interface cga_linedoubler_if #(
    parameter int PIX_W = 4
);
    logic             in_ce;
    logic             line_reset;
    logic [PIX_W-1:0] video_in;
    logic [1:0]       scan_mode;
    logic [PIX_W-1:0] dbl_video;
    logic             dbl_hsync;
    logic             dbl_de;
    logic             dbl_line;
    logic             overflow;

    modport master (
        output in_ce, line_reset, video_in, scan_mode,
        input  dbl_video, dbl_hsync, dbl_de, dbl_line, overflow
    );

    modport slave (
        input  in_ce, line_reset, video_in, scan_mode,
        output dbl_video, dbl_hsync, dbl_de, dbl_line, overflow
    );
endinterface

// File: rtl/cga_linebuf_dp.sv
// Ping-pong line store: one write port, one registered read port (block-RAM friendly).
module cga_linebuf_dp #(
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W:0]   waddr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W:0]   raddr_i,
    output logic [PIX_W-1:0]  rdata_o
);
    logic [PIX_W-1:0] mem_q [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/cga_linedoubler.sv
// 15 kHz -> 31 kHz scandoubler: each input line is stored in one bank and replayed twice from the other.
module cga_linedoubler
    import cga_video_pkg::*;
#(
    parameter int PIX_W    = 4,
    parameter int MAX_LINE = 1024,
    parameter int CE_DIV   = 2,
    parameter int HSYNC_W  = 16,
    parameter int ADDR_W   = $clog2(MAX_LINE)
) (
    input logic              clk,
    input logic              reset,
    cga_linedoubler_if.slave bus
);
    localparam int HALF  = CE_DIV / 2;
    localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int HS_CW = (HSYNC_W > 1) ? $clog2(HSYNC_W) : 1;
    localparam int LEN_W = ADDR_W + 1;

    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d, line_len_q, line_len_d, rd_ptr_q, rd_ptr_d;
    logic             bank_q, bank_d, ovf_q, ovf_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [HS_CW-1:0] hs_cnt_q, hs_cnt_d;
    out_state_e       state_q, state_d;
    scan_mode_e       scan_q, scan_d;
    logic             hsync_q, hsync_d, de_q, de_d, line_q, line_d;

    logic             we, re, slot;
    logic [ADDR_W:0]  waddr, raddr;
    logic [PIX_W-1:0] rdata;

    assign slot  = (phase_q == PH_W'(HALF - 1));
    assign raddr = {~bank_q, rd_ptr_q[ADDR_W-1:0]};

    cga_linebuf_dp #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_buf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (bus.video_in),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // A coincident in_ce lands as pixel 0 of the new line, in the bank being opened.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        line_len_d = line_len_q;
        bank_d     = bank_q;
        ovf_d      = ovf_q;
        we         = 1'b0;
        waddr      = {bank_q, wr_ptr_q[ADDR_W-1:0]};
        if (bus.line_reset) begin
            line_len_d = wr_ptr_q;
            bank_d     = ~bank_q;
            wr_ptr_d   = bus.in_ce ? LEN_W'(1) : '0;
            we         = bus.in_ce;
            waddr      = {~bank_q, {ADDR_W{1'b0}}};
        end else if (bus.in_ce) begin
            if (wr_ptr_q == LEN_W'(MAX_LINE)) begin
                ovf_d = 1'b1;
            end else begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + LEN_W'(1);
            end
        end
    end

    // Output side advances once per slot; the status flags are registered alongside the RAM read.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        hs_cnt_d = hs_cnt_q;
        scan_d   = scan_q;
        hsync_d  = hsync_q;
        de_d     = de_q;
        line_d   = line_q;
        re       = 1'b0;
        phase_d  = slot ? '0 : phase_q + PH_W'(1);
        if (bus.line_reset) begin
            state_d  = ST_SYNC0;
            rd_ptr_d = '0;
            hs_cnt_d = '0;
            phase_d  = '0;
            hsync_d  = 1'b0;
            de_d     = 1'b0;
            line_d   = 1'b0;
        end else if (slot) begin
            hsync_d = (state_q == ST_SYNC0) || (state_q == ST_SYNC1);
            line_d  = (state_q == ST_SYNC1) || (state_q == ST_LINE1);
            de_d    = 1'b0;
            case (state_q)
                ST_SYNC0, ST_SYNC1: begin
                    if (hs_cnt_q == HS_CW'(HSYNC_W - 1)) begin
                        hs_cnt_d = '0;
                        state_d  = (state_q == ST_SYNC0) ? ST_LINE0 : ST_LINE1;
                    end else begin
                        hs_cnt_d = hs_cnt_q + HS_CW'(1);
                    end
                end
                ST_LINE0, ST_LINE1: begin
                    if (rd_ptr_q == line_len_q) begin
                        rd_ptr_d = '0;
                        if (state_q == ST_LINE0) begin
                            state_d = ST_SYNC1;
                            scan_d  = scan_mode_e'(bus.scan_mode);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        re       = 1'b1;
                        de_d     = 1'b1;
                        rd_ptr_d = rd_ptr_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            line_len_q <= '0;
            rd_ptr_q   <= '0;
            bank_q     <= 1'b0;
            ovf_q      <= 1'b0;
            phase_q    <= '0;
            hs_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            scan_q     <= SCAN_OFF;
            hsync_q    <= 1'b0;
            de_q       <= 1'b0;
            line_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            line_len_q <= line_len_d;
            rd_ptr_q   <= rd_ptr_d;
            bank_q     <= bank_d;
            ovf_q      <= ovf_d;
            phase_q    <= phase_d;
            hs_cnt_q   <= hs_cnt_d;
            state_q    <= state_d;
            scan_q     <= scan_d;
            hsync_q    <= hsync_d;
            de_q       <= de_d;
            line_q     <= line_d;
        end
    end

    always_comb begin
        bus.dbl_video = '0;
        if (de_q) begin
            bus.dbl_video = rdata;
            if (line_q && scan_q == SCAN_BLACK) bus.dbl_video = '0;
            if (line_q && scan_q == SCAN_HALF)  bus.dbl_video = rdata >> 1;
        end
    end

    assign bus.dbl_hsync = hsync_q;
    assign bus.dbl_de    = de_q;
    assign bus.dbl_line  = line_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cga_linedoubler.sv
// Bench for cga_linedoubler: two instances (deep and 16-pixel buffers) against a line-timeline model.
module tb_cga_linedoubler;
    import cga_video_pkg::*;

    localparam int HS = 16;

    typedef struct packed {
        logic       r;
        logic       c;
        logic       l;
        logic [3:0] v;
        logic [1:0] s;
    } stim_t;

    logic       clk = 1'b0, reset = 1'b1, ce = 1'b0, lr = 1'b0;
    logic [3:0] vin = 4'h0;
    logic [1:0] sm = 2'd0;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    cga_linedoubler_if #(.PIX_W(4)) bus0 ();
    cga_linedoubler_if #(.PIX_W(4)) bus1 ();

    assign bus0.in_ce = ce;  assign bus0.line_reset = lr;  assign bus0.video_in = vin;  assign bus0.scan_mode = sm;
    assign bus1.in_ce = ce;  assign bus1.line_reset = lr;  assign bus1.video_in = vin;  assign bus1.scan_mode = sm;

    cga_linedoubler #(.PIX_W(4), .MAX_LINE(128), .CE_DIV(2), .HSYNC_W(HS)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    cga_linedoubler #(.PIX_W(4), .MAX_LINE(16), .CE_DIV(2), .HSYNC_W(HS)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    logic [7:0] obs [2];
    assign obs[0] = {bus0.dbl_video, bus0.dbl_hsync, bus0.dbl_de, bus0.dbl_line, bus0.overflow};
    assign obs[1] = {bus1.dbl_video, bus1.dbl_hsync, bus1.dbl_de, bus1.dbl_line, bus1.overflow};

    // Model: pixel lists per line and a clock count k since the last line_reset.
    logic [3:0] wr_buf [2][256];
    logic [3:0] rd_buf [2][256];
    int         wr_n [2] = '{0, 0};
    int         rd_n [2] = '{0, 0};
    int         k    [2] = '{0, 0};
    int         maxl [2] = '{128, 16};
    bit         act  [2] = '{1'b0, 1'b0};
    bit         ovf  [2] = '{1'b0, 1'b0};
    logic [1:0] scan_s [2] = '{2'd0, 2'd0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                act[d] = 1'b0; k[d] = 0; wr_n[d] = 0; ovf[d] = 1'b0;
            end else begin
                if (act[d] && k[d] < 1000) begin
                    k[d]++;
                    if (k[d] == HS + rd_n[d] + 1) scan_s[d] = sm;
                end
                if (lr) begin
                    for (int j = 0; j < wr_n[d]; j++) rd_buf[d][j] = wr_buf[d][j];
                    rd_n[d] = wr_n[d]; wr_n[d] = 0; act[d] = 1'b1; k[d] = 0;
                end
                if (ce) begin
                    if (wr_n[d] < maxl[d]) begin wr_buf[d][wr_n[d]] = vin; wr_n[d]++; end
                    else ovf[d] = 1'b1;
                end
            end
        end
    end

    // Line timeline: sync0, line0, gap slot, sync1, line1, final slot, idle.
    function automatic logic [7:0] expect_out(int d);
        int         L  = rd_n[d];
        int         kk = k[d];
        logic [3:0] v  = 4'h0, p;
        logic       hs = 1'b0, de = 1'b0, ln = 1'b0;
        if (act[d] && kk > 0) begin
            if (kk <= HS) hs = 1'b1;
            else if (kk <= HS + L) begin de = 1'b1; v = rd_buf[d][kk-HS-1]; end
            else if (kk == HS + L + 1) ;
            else if (kk <= 2*HS + L + 1) begin hs = 1'b1; ln = 1'b1; end
            else if (kk <= 2*HS + 2*L + 1) begin
                de = 1'b1; ln = 1'b1; p = rd_buf[d][kk-2*HS-L-2];
                v = (scan_s[d] == SCAN_BLACK) ? 4'h0 : (scan_s[d] == SCAN_HALF) ? (p >> 1) : p;
            end
            else if (kk == 2*HS + 2*L + 2) ln = 1'b1;
        end
        return {v, hs, de, ln, ovf[d]};
    endfunction

    stim_t      sq [$];
    logic [1:0] sm_cur = 2'd0;

    function automatic void put(logic r, logic c, logic l, logic [3:0] v);
        sq.push_back('{r: r, c: c, l: l, v: v, s: sm_cur});
    endfunction
    function automatic void add_idle(int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0, 4'h0);
    endfunction
    function automatic void add_lr();
        put(1'b0, 1'b0, 1'b1, 4'h0);
    endfunction
    // mode 0: 1,2,3..  mode 1: constant  mode 2: random; one pixel every 2 clk
    function automatic void add_pixels(int n, int mode, logic [3:0] cval);
        for (int i = 0; i < n; i++) begin
            put(1'b0, 1'b1, 1'b0, (mode == 0) ? 4'(i + 1) : (mode == 1) ? cval : 4'($urandom_range(0, 15)));
            put(1'b0, 1'b0, 1'b0, 4'h0);
        end
    endfunction

    task automatic step(input stim_t st);
        @(negedge clk);
        reset = st.r; ce = st.c; lr = st.l; vin = st.v; sm = st.s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sq.delete();
        for (int i = 0; i < 4; i++)
            put(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        foreach (sq[i]) begin
            step(sq[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== 8'h00) $display("FAIL reset dut%0d cyc%0d got=%h exp=00", d, i, obs[d]);
                else passed++;
            end
        end
    endtask

    task automatic test_basic();
        sq.delete(); sm_cur = 2'd0;
        add_pixels(8, 0, 4'h0); add_lr(); add_pixels(8, 0, 4'h0); add_idle(60);
        foreach (sq[i]) begin
            step(sq[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL basic dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
    endtask

    // Scan mode flips after the sample point; the second copy must keep the sampled mode.
    task automatic test_scan();
        sq.delete();
        for (int m = 1; m <= 2; m++) begin
            sm_cur = 2'(m);
            add_lr(); add_pixels(8, 1, 4'hE); add_idle(40); add_lr(); add_idle(30);
            sm_cur = 2'(3 - m);
            add_idle(40);
        end
        foreach (sq[i]) begin
            step(sq[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL scan dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
    endtask

    task automatic test_overflow();
        sq.delete(); sm_cur = 2'd0;
        add_lr(); add_pixels(20, 2, 4'h0); add_lr(); add_pixels(20, 2, 4'h0); add_idle(80);
        foreach (sq[i]) begin
            step(sq[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL overflow dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
        total++;
        if (bus1.overflow !== 1'b1 || bus0.overflow !== 1'b0)
            $display("FAIL overflow_sticky got=%b%b exp=01", bus0.overflow, bus1.overflow);
        else passed++;
    endtask

    task automatic test_abort();
        sq.delete(); sm_cur = 2'd2;
        add_lr(); add_pixels(100, 2, 4'h0); add_lr(); add_pixels(30, 2, 4'h0);
        add_lr(); add_pixels(8, 2, 4'h0); add_idle(10); add_lr(); add_idle(80);
        foreach (sq[i]) begin
            step(sq[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL abort dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
    endtask

    task automatic test_empty();
        int   rises = 0;
        logic de_seen = 1'b0, hs_prev = 1'b0;
        sq.delete(); sm_cur = 2'd0;
        add_lr(); add_lr(); add_idle(50);
        foreach (sq[i]) begin
            step(sq[i]);
            de_seen |= bus0.dbl_de | bus1.dbl_de;
            if (bus0.dbl_hsync && !hs_prev) rises++;
            hs_prev = bus0.dbl_hsync;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL empty dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
        total++;
        if (de_seen !== 1'b0 || rises != 2) $display("FAIL empty_pulses de_seen=%b hsync_pulses=%0d exp de=0 pulses=2", de_seen, rises);
        else passed++;
    endtask

    task automatic test_coincident();
        int         lr_idx;
        logic       got = 1'b0;
        logic [3:0] first_v = 4'h0;
        sq.delete(); sm_cur = 2'd0;
        add_lr(); add_pixels(5, 2, 4'h0);
        put(1'b0, 1'b1, 1'b1, 4'h5); add_pixels(3, 2, 4'h0);
        lr_idx = sq.size(); add_lr(); add_idle(60);
        foreach (sq[i]) begin
            step(sq[i]);
            if (i > lr_idx && !got && bus0.dbl_de) begin got = 1'b1; first_v = bus0.dbl_video; end
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL coincident dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
        total++;
        if (got !== 1'b1 || first_v !== 4'h5) $display("FAIL coincident_first got=%h seen=%b exp=5", first_v, got);
        else passed++;
    endtask

    task automatic test_random();
        sq.delete();
        for (int n = 0; n < 10; n++) begin
            sm_cur = 2'($urandom_range(0, 3));
            add_lr();
            for (int j = 0; j < int'($urandom_range(0, 40)); j++) begin
                put(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
                add_idle(int'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 5) == 0) put(1'b1, 1'b0, 1'b0, 4'h0);
            sm_cur = 2'($urandom_range(0, 3));
            add_idle(int'($urandom_range(0, 60)));
        end
        add_lr(); add_idle(130);
        foreach (sq[i]) begin
            step(sq[i]);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs[d] !== expect_out(d)) $display("FAIL random dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], expect_out(d));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scan();
        test_overflow();
        test_abort();
        test_empty();
        test_coincident();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cga_linedoubler.md
Name: cga_linedoubler

Overview:
Parametrised successor to the fixed 4-bit CGA scandoubler. It converts a 15 kHz pixel stream into a 31 kHz stream by writing each input line into one half of a ping-pong line buffer and reading the other half out twice at double pixel rate.
- Adds configurable pixel width, maximum line length, clock divide, hsync width and a runtime scanline mode.
- Sits between the CGA pixel pusher and the hsync_sd/video_sd output mux. It is reusable for the 6-bit Tandy/EGA-style palette path.

Parameters:
PIX_W, 4, bits per pixel (4 = IRGB)
MAX_LINE, 1024, maximum pixels stored per input line; power of two
CE_DIV, 2, clk cycles per input pixel; even, >=2
HSYNC_W, 16, doubled hsync pulse width in output pixels
ADDR_W, $clog2(MAX_LINE), derived buffer address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
in_ce  in  1  input pixel strobe, one clk wide, nominally every CE_DIV clocks
line_reset  in  1  one-clk pulse marking start of an input line
video_in  in  PIX_W  input pixel, sampled when in_ce=1
scan_mode  in  2  0=off, 1=black 2nd line, 2=halve 2nd line (each bit >>1 of MSB-first value), 3=reserved(=off)
dbl_video  out  PIX_W  doubled-rate pixel
dbl_hsync  out  1  doubled-rate hsync, active high
dbl_de  out  1  high while a stored pixel is being output
dbl_line  out  1  0 = first copy, 1 = second copy of current line
overflow  out  1  sticky: an input line exceeded MAX_LINE

Behaviour:
- Reset: all outputs 0. wr_ptr=0, rd_ptr=0, line_len=0, bank=0, out state IDLE, phase counter 0, overflow cleared.
- Write side:
  - When in_ce=1 and wr_ptr<MAX_LINE, write video_in to buffer[bank][wr_ptr] and increment wr_ptr.
  - When in_ce=1 and wr_ptr==MAX_LINE, drop the pixel and set overflow (sticky until reset).
- line_reset:
  - line_len <= wr_ptr (saturated at MAX_LINE); bank <= ~bank; wr_ptr <= 0.
  - Out FSM enters SYNC0 with rd_ptr=0 and phase=0.
  - line_reset and in_ce in the same cycle: the pixel is written as pixel 0 of the new line, into the new bank, and wr_ptr becomes 1.
- Output pixel clock: phase counts 0..CE_DIV/2-1 and wraps. One output pixel slot occurs per wrap, i.e. 2x the input rate.
- Out FSM states: IDLE, SYNC0, LINE0, SYNC1, LINE1.
  - SYNC0 / SYNC1:
    - dbl_hsync=1 for HSYNC_W slots; dbl_de=0; dbl_video=0.
    - dbl_line=0 in SYNC0 and 1 in SYNC1.
    - SYNC0 exits to LINE0 and SYNC1 exits to LINE1.
  - LINE0 / LINE1:
    - Read buffer[~bank][rd_ptr] each slot; rd_ptr increments.
    - Read latency is 1 clk: dbl_video/dbl_de are registered 1 clk after the address is presented.
    - When rd_ptr==line_len: LINE0 goes to SYNC1 with rd_ptr=0; LINE1 goes to IDLE.
  - IDLE: dbl_video=0, dbl_de=0, dbl_hsync=0.
- line_len=0: LINE states exit immediately. Both hsync pulses are still produced; dbl_de stays 0.
- line_reset arriving in any non-IDLE state aborts the current output and restarts at SYNC0. Output is truncated, never overlapped.
- scan_mode is applied only when dbl_line=1 and dbl_de=1:
  - mode 1: dbl_video=0.
  - mode 2: dbl_video = pixel >> 1.
  - It is sampled at entry to SYNC1 so a mid-line change does not tear the line.
- reset asserted mid-line: immediate return to the reset state. Buffer contents are don't-care.

Decomposition:
- Package cga_video_pkg:
  - scan_mode encodings SCAN_OFF/SCAN_BLACK/SCAN_HALF.
  - Out-FSM state enum.
- Sub-module cga_linebuf_dp: simple dual-port RAM, depth 2*MAX_LINE, width PIX_W.
  - Write port: {bank, wr_ptr}.
  - Registered read port: {~bank, rd_ptr}, 1-clk latency, inferable as block RAM.

Test Plan:
1. Reset, then CE_DIV=2, 8 pixels 1..8 with in_ce every 2 clk, then line_reset, then 8 more pixels. Required: 16-slot dbl_hsync; dbl_video 1..8 at one pixel per clk with dbl_line=0; second hsync; 1..8 again with dbl_line=1; then IDLE.
2. scan_mode=1 then 2, pixel value 4'hE. Required: second copy outputs 0, then 4'h7. First copy is 4'hE in both cases.
3. MAX_LINE=16, 20 pixels per line. Required: overflow rises at the 17th pixel and stays high; output lines are 16 pixels.
4. Second line_reset during LINE0 of a 100-pixel line. Required: SYNC0 restarts on the next clk with no LINE1, and new data is read from the other bank.
5. Back-to-back line_reset with no pixels. Required: two hsync pulses, dbl_de never asserted.
6. line_reset coincident with in_ce carrying 4'h5. Required: first output pixel of the next doubled line is 4'h5.
